// File: rtl/main_memory.sv
// Burst-capable word memory with configurable read latency.
// Define MAIN_MEMORY_OOR_ERR_EN to add the sticky out-of-range err output.
module main_memory #(
   parameter int unsigned DEPTH_WORDS = 262144,
   parameter logic [31:0] START_ADDR  = 32'h80020000,
   parameter int unsigned READ_LAT    = 1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        enable,
   input  logic [31:0] address,
   input  logic        read_not_write,
   input  logic [1:0]  access_size,
   input  logic [31:0] data_in,
   output logic [31:0] data_out,
   output logic        rd_valid,
   output logic        busy
`ifdef MAIN_MEMORY_OOR_ERR_EN
   ,
   output logic        err
`endif
);

   localparam int IDX_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
   localparam logic [29:0] START_W = START_ADDR[31:2];
   localparam logic [2:0] WAIT_INIT =
      (READ_LAT > 1) ? 3'(READ_LAT - 2) : 3'd0;

   typedef enum logic [1:0] {
      IDLE,
      RD_WAIT,
      RD_BURST,
      WR_BURST
   } state_t;

   state_t state, state_nx;

   logic [31:0] mem [DEPTH_WORDS];

   logic [29:0] waddr_q, beat_addr, off;
   logic [4:0]  cnt_q, beat_cnt;
   logic [2:0]  wait_q;
   logic [IDX_W-1:0] idx;
   logic        accept, load, wr_en, in_range;
   logic [31:0] rd_word;
   logic        unused_bits;

   function automatic logic [4:0] burst_len(input logic [1:0] sz);
      case (sz)
         2'b00:   return 5'd1;
         2'b01:   return 5'd4;
         2'b10:   return 5'd8;
         default: return 5'd16;
      endcase
   endfunction

   // In IDLE the beat comes straight from the request inputs.
   assign accept    = (state == IDLE) && enable;
   assign beat_addr = (state == IDLE) ? address[31:2] : waddr_q;
   assign beat_cnt  = (state == IDLE) ? burst_len(access_size) : cnt_q;
   assign off       = beat_addr - START_W;
   assign in_range  = (beat_addr >= START_W) &&
                      ({2'b00, off} < 32'(DEPTH_WORDS));
   assign idx       = off[IDX_W-1:0];
   assign rd_word   = in_range ? mem[idx] : 32'h0;
   assign busy      = (state != IDLE);
   assign unused_bits = ^{address[1:0], off};

   always_comb begin
      state_nx = state;
      load     = 1'b0;
      wr_en    = 1'b0;
      unique case (state)
         IDLE: begin
            if (enable) begin
               if (read_not_write) begin
                  if (READ_LAT == 1) begin
                     state_nx = RD_BURST;
                     load     = 1'b1;
                  end else begin
                     state_nx = RD_WAIT;
                  end
               end else begin
                  wr_en = 1'b1;
                  if (beat_cnt != 5'd1)
                     state_nx = WR_BURST;
               end
            end
         end
         RD_WAIT: begin
            if (wait_q == 3'd0) begin
               state_nx = RD_BURST;
               load     = 1'b1;
            end
         end
         RD_BURST: begin
            if (cnt_q == 5'd0)
               state_nx = IDLE;
            else
               load = 1'b1;
         end
         WR_BURST: begin
            wr_en = 1'b1;
            if (cnt_q == 5'd1)
               state_nx = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state    <= IDLE;
         waddr_q  <= '0;
         cnt_q    <= '0;
         wait_q   <= '0;
         data_out <= '0;
         rd_valid <= 1'b0;
      end else begin
         state    <= state_nx;
         rd_valid <= load;
         if (load)
            data_out <= rd_word;
         if (accept) begin
            waddr_q <= beat_addr;
            cnt_q   <= beat_cnt;
            wait_q  <= WAIT_INIT;
         end
         // cnt_q counts beats not yet transferred
         if (load || wr_en) begin
            waddr_q <= beat_addr + 30'd1;
            cnt_q   <= beat_cnt - 5'd1;
         end
         if (state == RD_WAIT)
            wait_q <= wait_q - 3'd1;
      end
   end

   // Storage is never reset so contents survive rst.
   always_ff @(posedge clk) begin
      if (wr_en && in_range)
         mem[idx] <= data_in;
   end

`ifdef MAIN_MEMORY_OOR_ERR_EN
   always_ff @(posedge clk or negedge rst) begin
      if (!rst)
         err <= 1'b0;
      else if ((load || wr_en) && !in_range)
         err <= 1'b1;
   end
`endif

endmodule

// File: tb/tb_main_memory.sv
// Bench for main_memory: READ_LAT=1 and READ_LAT=3 copies share stimulus
// and are checked cycle by cycle against an array model of the storage.
module tb_main_memory;

   localparam logic [31:0] START = 32'h80020000;
   localparam int DEPTH = 1024;

   logic clk = 1'b0;
   logic rst = 1'b0;
   logic enable = 1'b0;
   logic rnw = 1'b0;
   logic [31:0] address = '0;
   logic [31:0] data_in = '0;
   logic [1:0]  access_size = '0;
   logic [31:0] dout1, dout3;
   logic rv1, rv3, busy1, busy3;
`ifdef MAIN_MEMORY_OOR_ERR_EN
   logic err1, err3;
`endif

   logic [31:0] mm [DEPTH];
   logic [31:0] wdat [16];
   logic [31:0] exp_d1 = '0;
   logic [31:0] exp_d3 = '0;
   bit   err_exp = 1'b0;
   int   total = 0;
   int   bad = 0;

   always #5 clk = ~clk;

   main_memory #(
      .DEPTH_WORDS(DEPTH), .START_ADDR(START), .READ_LAT(1)
   ) u1 (
      .clk(clk), .rst(rst), .enable(enable), .address(address),
      .read_not_write(rnw), .access_size(access_size),
      .data_in(data_in), .data_out(dout1), .rd_valid(rv1),
      .busy(busy1)
`ifdef MAIN_MEMORY_OOR_ERR_EN
      , .err(err1)
`endif
   );

   main_memory #(
      .DEPTH_WORDS(DEPTH), .START_ADDR(START), .READ_LAT(3)
   ) u3 (
      .clk(clk), .rst(rst), .enable(enable), .address(address),
      .read_not_write(rnw), .access_size(access_size),
      .data_in(data_in), .data_out(dout3), .rd_valid(rv3),
      .busy(busy3)
`ifdef MAIN_MEMORY_OOR_ERR_EN
      , .err(err3)
`endif
   );

   task automatic chk(input string tag, input logic [31:0] o,
                      input logic [31:0] e);
      total++;
      assert (o === e) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, o, e);
      end
   endtask

   task automatic chk1(input string tag, input logic o, input logic e);
      total++;
      assert (o === e) else begin
         bad++;
         $error("FAIL %s observed=%b expected=%b", tag, o, e);
      end
   endtask

   function automatic int blen(input logic [1:0] s);
      return (s == 2'b00) ? 1 : (s == 2'b01) ? 4 : (s == 2'b10) ? 8 : 16;
   endfunction

   function automatic bit in_rng(input logic [31:0] b);
      return (b >= START) && (((b - START) >> 2) < 32'(DEPTH));
   endfunction

   function automatic int idx_of(input logic [31:0] b);
      return int'((b - START) >> 2);
   endfunction

   task automatic chk_err();
`ifdef MAIN_MEMORY_OOR_ERR_EN
      chk1("err1", err1, err_exp);
      chk1("err3", err3, err_exp);
`endif
   endtask

   task automatic fill_rand();
      for (int i = 0; i < 16; i++) wdat[i] = $urandom;
   endtask

   // Entered and left at a falling edge.
   task automatic do_wr(input logic [31:0] a, input logic [1:0] s,
                        input int abort);
      int n = blen(s);
      logic [31:0] b;
      enable = 1'b1; rnw = 1'b0; address = a; access_size = s;
      for (int i = 0; i < n; i++) begin
         data_in = wdat[i];
         @(posedge clk);
         b = {a[31:2], 2'b00} + 32'(4 * i);
         if (in_rng(b)) mm[idx_of(b)] = wdat[i];
         else err_exp = 1'b1;
         #1 enable = 1'b0;
         if (abort == i + 1) begin
            rst = 1'b0;
            #1;
            chk1("rst_busy1", busy1, 1'b0);
            chk1("rst_busy3", busy3, 1'b0);
            chk1("rst_valid1", rv1, 1'b0);
            chk("rst_dout1", dout1, 32'h0);
            chk("rst_dout3", dout3, 32'h0);
            exp_d1 = '0; exp_d3 = '0; err_exp = 1'b0;
            chk_err();
            @(negedge clk);
            rst = 1'b1;
            return;
         end
         @(negedge clk);
         chk1("wr_busy1", busy1, i < n - 1);
         chk1("wr_busy3", busy3, i < n - 1);
         chk1("wr_valid1", rv1, 1'b0);
         chk1("wr_valid3", rv3, 1'b0);
      end
      chk_err();
   endtask

   task automatic do_rd(input logic [31:0] a, input logic [1:0] s,
                        input bit pulse);
      int n = blen(s);
      logic [31:0] eb [16];
      logic [31:0] b;
      for (int i = 0; i < n; i++) begin
         b = {a[31:2], 2'b00} + 32'(4 * i);
         eb[i] = in_rng(b) ? mm[idx_of(b)] : 32'h0;
         if (!in_rng(b)) err_exp = 1'b1;
      end
      enable = 1'b1; rnw = 1'b1; address = a; access_size = s;
      @(negedge clk);
      enable = 1'b0;
      for (int k = 0; k < n + 4; k++) begin
         if (pulse && k == 2) begin
            enable = 1'b1; rnw = 1'b0; address = START + 32'h200;
            access_size = 2'b11; data_in = $urandom;
         end
         if (pulse && k == 3) enable = 1'b0;
         if (k < n) exp_d1 = eb[k];
         if (k >= 2 && k < n + 2) exp_d3 = eb[k-2];
         chk1("rd_valid1", rv1, k < n);
         chk("rd_data1", dout1, exp_d1);
         chk1("rd_busy1", busy1, k < n);
         chk1("rd_valid3", rv3, k >= 2 && k < n + 2);
         chk("rd_data3", dout3, exp_d3);
         chk1("rd_busy3", busy3, k < n + 2);
         @(negedge clk);
      end
      chk_err();
   endtask

   initial begin
      logic [31:0] a;
      logic [1:0]  s;
      @(negedge clk);
      chk1("reset_busy1", busy1, 1'b0);
      chk1("reset_busy3", busy3, 1'b0);
      chk1("reset_valid1", rv1, 1'b0);
      chk1("reset_valid3", rv3, 1'b0);
      chk("reset_dout1", dout1, 32'h0);
      chk("reset_dout3", dout3, 32'h0);
      chk_err();

      // first edge out of reset accepts; misaligned address lands on 0x10
      rst = 1'b1;
      wdat[0] = 32'hDEADBEEF;
      do_wr(32'h80020013, 2'b00, 0);
      do_rd(32'h80020010, 2'b00, 1'b0);

      for (int j = 0; j < DEPTH / 16; j++) begin
         fill_rand();
         do_wr(START + 32'(64 * j), 2'b11, 0);
      end

      for (int i = 0; i < 4; i++) wdat[i] = 32'(i + 1);
      do_wr(32'h80020100, 2'b01, 0);
      do_rd(32'h80020100, 2'b01, 1'b0);

      do_rd(START + 32'h300, 2'b11, 1'b1);
      do_rd(START + 32'h200, 2'b11, 1'b0);

      do_rd(32'h80000000, 2'b01, 1'b0);

      fill_rand();
      do_wr(START + 32'(4 * (DEPTH - 4)), 2'b10, 0);
      do_rd(START + 32'(4 * (DEPTH - 8)), 2'b11, 1'b0);

      fill_rand();
      do_wr(START + 32'h400, 2'b10, 3);
      do_rd(START + 32'h400, 2'b10, 1'b0);

      for (int t = 0; t < 40; t++) begin
         s = 2'($urandom_range(0, 3));
         if ($urandom_range(0, 9) == 0)
            a = START - 32'(4 * $urandom_range(1, 20));
         else
            a = START + 32'(4 * $urandom_range(0, DEPTH + 8));
         a[1:0] = 2'($urandom);
         if ($urandom_range(0, 1) == 1) begin
            fill_rand();
            do_wr(a, s, 0);
         end else begin
            do_rd(a, s, (s == 2'b11) && ($urandom_range(0, 1) == 1));
         end
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/main_memory.md
MAIN_MEMORY -- requirements
Module: main_memory

Interface
REQ-001 SHALL have parameter DEPTH_WORDS, default 262144; this is the storage depth in 32-bit words.
REQ-002 SHALL have parameter START_ADDR, default 32'h80020000; this is the byte address mapped to word 0.
REQ-003 SHALL have parameter READ_LAT, default 1, legal range 1..8; this is the number of cycles from request accept to the first read beat.
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all state is on its rising edge.
REQ-005 SHALL have port rst, input, 1 bit: asynchronous, active-low reset.
REQ-006 SHALL have port enable, input, 1 bit: request strobe, sampled only in IDLE.
REQ-007 SHALL have port address, input, 32 bits: byte address of the first beat; bits [1:0] are ignored.
REQ-008 SHALL have port read_not_write, input, 1 bit: 1 = read, 0 = write.
REQ-009 SHALL have port access_size, input, 2 bits: burst length; 00 = 1 word, 01 = 4, 10 = 8, 11 = 16.
REQ-010 SHALL have port data_in, input, 32 bits: write data for the beat currently being written.
REQ-011 SHALL have port data_out, output, 32 bits: read data, registered.
REQ-012 SHALL have port rd_valid, output, 1 bit: data_out holds a valid read beat this cycle.
REQ-013 SHALL have port busy, output, 1 bit: a request is in progress; new requests are ignored.

Function
REQ-014 SHALL implement a four-state FSM: IDLE, RD_WAIT, RD_BURST, WR_BURST.
REQ-015 IDLE with enable=1 SHALL accept the request: latch the word address (address>>2), the beat count from access_size, and the direction.
REQ-016 A read accept SHALL move IDLE->RD_WAIT; RD_WAIT SHALL last READ_LAT-1 cycles (zero when READ_LAT=1), then move to RD_BURST.
REQ-017 RD_BURST SHALL drive one beat per cycle with rd_valid=1 and consecutive word addresses (+4 bytes), for exactly the burst length, then return to IDLE.
REQ-018 For a read accepted at edge T, the first rd_valid SHALL appear in the cycle after edge T+READ_LAT-1, so data is usable at edge T+READ_LAT.
REQ-019 A write accept SHALL store data_in to the first word on the accept edge; for bursts longer than 1, WR_BURST SHALL store data_in to each following word on each following edge, then return to IDLE.
REQ-020 busy SHALL be 1 from the cycle after accept until the FSM is back in IDLE; a single-word write SHALL produce no busy cycle.
REQ-021 enable asserted while busy=1 SHALL be ignored and have no side effects.
REQ-022 A beat whose word index, (addr-START_ADDR)>>2, is at or beyond DEPTH_WORDS or below START_ADDR SHALL be out of range: reads return 32'h0, writes are dropped, and the burst continues normally.
REQ-023 The word index SHALL be computed modulo 2^30; no wrap-around into the array occurs.
REQ-024 data_out SHALL hold its last value when rd_valid=0.
REQ-025 A read of a word written by an earlier completed request SHALL return the written value (write-then-read coherence).

Reset
REQ-026 rst=0 SHALL, asynchronously, force state=IDLE, busy=0, rd_valid=0, data_out=0, and clear the beat counter and latched address.
REQ-027 Reset SHALL not clear storage contents; words written before a mid-burst reset SHALL persist, and remaining beats SHALL be abandoned.
REQ-028 The first request SHALL be accepted on the first rising edge with rst=1 and enable=1.

Configuration
REQ-029 With macro MAIN_MEMORY_OOR_ERR_EN defined, the block SHALL add output port err (1 bit), which is set sticky on any out-of-range beat and cleared only by rst.
REQ-030 Without MAIN_MEMORY_OOR_ERR_EN, the err port and its logic SHALL be absent and all other behaviour SHALL be unchanged.

Verification
REQ-031 Single write then read: write 0xDEADBEEF at 0x80020010 with access_size=00, then read it with READ_LAT=1 -> rd_valid for one cycle with data_out=0xDEADBEEF at the expected edge.
REQ-032 4-beat write burst at 0x80020100 with data 1,2,3,4, then a 4-beat read with READ_LAT=3 -> two idle cycles, then 4 consecutive rd_valid beats of 1,2,3,4, with busy held high throughout.
REQ-033 enable pulsed during an active 16-beat read -> ignored; exactly 16 beats are delivered and the second request is not executed.
REQ-034 Read at 0x80000000 (below START_ADDR) with access_size=01 -> 4 beats of 0x0, and err=1 when MAIN_MEMORY_OOR_ERR_EN is defined.
REQ-035 rst=0 asserted after beat 3 of an 8-beat write -> busy=0 immediately; a subsequent read returns beats 1-3 written and beats 4-8 unchanged from their prior contents.
REQ-036 address=0x80020013 (misaligned) on a write -> data is stored at word 0x80020010.
